// File: rtl/regfile_wb_ctrl.sv
// Writeback controller for the 16x16 register file: result queue, busy scoreboard
// and registered write port. Define WB_FWD_EN to forward queued results to sources.
module regfile_wb_ctrl #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rsv_valid,
   input  logic [3:0]  rsv_reg,
   output logic        rsv_stall,
   input  logic        wb_valid,
   output logic        wb_ready,
   input  logic [3:0]  wb_reg,
   input  logic [15:0] wb_data,
   input  logic [3:0]  SrcReg1,
   input  logic [3:0]  SrcReg2,
   output logic        src1_busy,
   output logic        src2_busy,
   output logic        fwd1_valid,
   output logic        fwd2_valid,
   output logic [15:0] fwd1_data,
   output logic [15:0] fwd2_data,
   output logic [3:0]  DstReg,
   output logic        WriteReg,
   output logic [15:0] DstData,
   output logic [2:0]  count,
   output logic        err
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [3:0]    q_reg_q  [DEPTH];
   logic [3:0]    q_reg_d  [DEPTH];
   logic [15:0]   q_data_q [DEPTH];
   logic [15:0]   q_data_d [DEPTH];
   logic [AW-1:0] head_q, head_d, tail_q, tail_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [15:0]   busy_q, busy_d;
   logic          wr_q, wr_d;
   logic [3:0]    dst_q, dst_d;
   logic [15:0]   data_q, data_d;
   logic          err_q, err_d;
   logic          wb_hs, push, pop;

   assign wb_ready  = {1'b0, cnt_q} < 4'(DEPTH);
   assign rsv_stall = rsv_valid & (rsv_reg != 4'd0) & busy_q[rsv_reg];
   assign wb_hs     = wb_valid & wb_ready;
   assign push      = wb_hs & (wb_reg != 4'd0) & busy_q[wb_reg];
   assign pop       = cnt_q != 3'd0;

   always_comb begin
      q_reg_d  = q_reg_q;
      q_data_d = q_data_q;
      head_d   = head_q;
      tail_d   = tail_q;
      busy_d   = busy_q;
      wr_d     = 1'b0;
      dst_d    = dst_q;
      data_d   = data_q;
      err_d    = err_q;
      // Commit clears first; a same-cycle reserve of that register is already stalled.
      if (wr_q)
         busy_d[dst_q] = 1'b0;
      if (rsv_valid && !rsv_stall && rsv_reg != 4'd0)
         busy_d[rsv_reg] = 1'b1;
      busy_d[0] = 1'b0;
      if (wb_hs && wb_reg != 4'd0 && !busy_q[wb_reg])
         err_d = 1'b1;
      if (push) begin
         q_reg_d[tail_q]  = wb_reg;
         q_data_d[tail_q] = wb_data;
         tail_d           = tail_q + 1'b1;
      end
      if (pop) begin
         wr_d   = 1'b1;
         dst_d  = q_reg_q[head_q];
         data_d = q_data_q[head_q];
         head_d = head_q + 1'b1;
      end
      cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            q_reg_q[i]  <= 4'd0;
            q_data_q[i] <= 16'd0;
         end
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= 3'd0;
         busy_q <= 16'd0;
         wr_q   <= 1'b0;
         dst_q  <= 4'd0;
         data_q <= 16'd0;
         err_q  <= 1'b0;
      end else begin
         q_reg_q  <= q_reg_d;
         q_data_q <= q_data_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         wr_q     <= wr_d;
         dst_q    <= dst_d;
         data_q   <= data_d;
         err_q    <= err_d;
      end
   end

`ifdef WB_FWD_EN
   logic [AW-1:0] idx;

   // WAW prevention leaves at most one match per register, so no priority is needed.
   always_comb begin
      fwd1_valid = 1'b0;
      fwd1_data  = 16'd0;
      fwd2_valid = 1'b0;
      fwd2_data  = 16'd0;
      idx        = head_q;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + AW'(i);
         if (4'(i) < {1'b0, cnt_q}) begin
            if (SrcReg1 != 4'd0 && q_reg_q[idx] == SrcReg1) begin
               fwd1_valid = 1'b1;
               fwd1_data  = q_data_q[idx];
            end
            if (SrcReg2 != 4'd0 && q_reg_q[idx] == SrcReg2) begin
               fwd2_valid = 1'b1;
               fwd2_data  = q_data_q[idx];
            end
         end
      end
      if (wr_q && SrcReg1 != 4'd0 && dst_q == SrcReg1) begin
         fwd1_valid = 1'b1;
         fwd1_data  = data_q;
      end
      if (wr_q && SrcReg2 != 4'd0 && dst_q == SrcReg2) begin
         fwd2_valid = 1'b1;
         fwd2_data  = data_q;
      end
   end

   assign src1_busy = busy_q[SrcReg1] & (SrcReg1 != 4'd0) & ~fwd1_valid;
   assign src2_busy = busy_q[SrcReg2] & (SrcReg2 != 4'd0) & ~fwd2_valid;
`else
   assign fwd1_valid = 1'b0;
   assign fwd1_data  = 16'd0;
   assign fwd2_valid = 1'b0;
   assign fwd2_data  = 16'd0;
   assign src1_busy  = busy_q[SrcReg1] & (SrcReg1 != 4'd0);
   assign src2_busy  = busy_q[SrcReg2] & (SrcReg2 != 4'd0);
`endif

   assign WriteReg = wr_q;
   assign DstReg   = dst_q;
   assign DstData  = data_q;
   assign count    = cnt_q;
   assign err      = err_q;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: per-cycle vector table plus hand sequences
// for streaming commits, forwarding and asynchronous reset mid-drain.
module tb_regfile_wb_ctrl;
`ifdef WB_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        rsv_valid, wb_valid;
   logic [3:0]  rsv_reg, wb_reg, SrcReg1, SrcReg2;
   logic [15:0] wb_data;
   logic        rsv_stall, wb_ready, src1_busy, src2_busy, fwd1_valid, fwd2_valid;
   logic [15:0] fwd1_data, fwd2_data, DstData;
   logic [3:0]  DstReg;
   logic        WriteReg, err;
   logic [2:0]  count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   regfile_wb_ctrl #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .rsv_valid(rsv_valid), .rsv_reg(rsv_reg), .rsv_stall(rsv_stall),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg), .wb_data(wb_data),
      .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
      .src1_busy(src1_busy), .src2_busy(src2_busy),
      .fwd1_valid(fwd1_valid), .fwd2_valid(fwd2_valid),
      .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
      .DstReg(DstReg), .WriteReg(WriteReg), .DstData(DstData),
      .count(count), .err(err)
   );

   typedef struct {
      logic        rv;  logic [3:0] rr;
      logic        wv;  logic [3:0] wr;  logic [15:0] wd;
      logic [3:0]  s1;  logic [3:0] s2;
      logic        e_stall, e_ready, e_s1b, e_hit1;
      logic [15:0] e_fd1;
      logic        e_s2b;
      logic        e_we;  logic [3:0] e_dst; logic [15:0] e_dd;
      logic [2:0]  e_cnt; logic e_err;
   } vec_t;

   vec_t vecs[17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rv, input logic [3:0] rr, input logic wv,
                        input logic [3:0] wr, input logic [15:0] wd,
                        input logic [3:0] s1, input logic [3:0] s2);
      rsv_valid = rv; rsv_reg = rr; wb_valid = wv; wb_reg = wr; wb_data = wd;
      SrcReg1 = s1; SrcReg2 = s2;
   endtask

   task automatic step(input logic rv, input logic [3:0] rr, input logic wv,
                       input logic [3:0] wr, input logic [15:0] wd);
      @(negedge clk);
      drive(rv, rr, wv, wr, wd, 4'd0, 4'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      // rv rr wv wr wd | s1 s2 | stall ready s1b hit1 fd1 s2b | we dst dd cnt err
      vecs[0]  = '{1,3, 0,0,16'h0,    3,0, 0,1,0,0,16'h0,    0, 0,0,16'h0,    0,0};
      vecs[1]  = '{0,0, 1,3,16'hBEEF, 3,0, 0,1,1,0,16'h0,    0, 0,0,16'h0,    1,0};
      vecs[2]  = '{0,0, 0,0,16'h0,    3,0, 0,1,1,1,16'hBEEF, 0, 1,3,16'hBEEF, 0,0};
      vecs[3]  = '{0,0, 0,0,16'h0,    3,0, 0,1,1,1,16'hBEEF, 0, 0,3,16'hBEEF, 0,0};
      vecs[4]  = '{0,0, 0,0,16'h0,    3,0, 0,1,0,0,16'h0,    0, 0,3,16'hBEEF, 0,0};
      vecs[5]  = '{1,5, 0,0,16'h0,    5,0, 0,1,0,0,16'h0,    0, 0,3,16'hBEEF, 0,0};
      vecs[6]  = '{1,5, 0,0,16'h0,    5,5, 1,1,1,0,16'h0,    1, 0,3,16'hBEEF, 0,0};
      vecs[7]  = '{1,5, 1,5,16'h0055, 5,5, 1,1,1,0,16'h0,    1, 0,3,16'hBEEF, 1,0};
      vecs[8]  = '{1,5, 0,0,16'h0,    5,0, 1,1,1,1,16'h0055, 0, 1,5,16'h0055, 0,0};
      vecs[9]  = '{1,5, 0,0,16'h0,    5,0, 1,1,1,1,16'h0055, 0, 0,5,16'h0055, 0,0};
      vecs[10] = '{1,5, 0,0,16'h0,    5,0, 0,1,0,0,16'h0,    0, 0,5,16'h0055, 0,0};
      vecs[11] = '{1,0, 1,0,16'hFFFF, 5,0, 0,1,1,0,16'h0,    0, 0,5,16'h0055, 0,0};
      vecs[12] = '{0,0, 1,7,16'h7777, 7,0, 0,1,0,0,16'h0,    0, 0,5,16'h0055, 0,1};
      vecs[13] = '{0,0, 1,5,16'h5555, 7,0, 0,1,0,0,16'h0,    0, 0,5,16'h0055, 1,1};
      vecs[14] = '{0,0, 0,0,16'h0,    5,0, 0,1,1,1,16'h5555, 0, 1,5,16'h5555, 0,1};
      vecs[15] = '{0,0, 0,0,16'h0,    5,0, 0,1,1,1,16'h5555, 0, 0,5,16'h5555, 0,1};
      vecs[16] = '{0,0, 0,0,16'h0,    5,0, 0,1,0,0,16'h0,    0, 0,5,16'h5555, 0,1};

      rst = 1'b1;
      drive(0, 0, 0, 0, 16'h0, 0, 0);
      #12;
      chk("rst_we",    32'(WriteReg), 32'd0);
      chk("rst_dst",   32'(DstReg),   32'd0);
      chk("rst_data",  32'(DstData),  32'd0);
      chk("rst_count", 32'(count),    32'd0);
      chk("rst_err",   32'(err),      32'd0);
      chk("rst_ready", 32'(wb_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      for (int v = 0; v < 17; v++) begin
         @(negedge clk);
         drive(vecs[v].rv, vecs[v].rr, vecs[v].wv, vecs[v].wr, vecs[v].wd,
               vecs[v].s1, vecs[v].s2);
         #1;
         chk($sformatf("v%0d_stall", v), 32'(rsv_stall), 32'(vecs[v].e_stall));
         chk($sformatf("v%0d_ready", v), 32'(wb_ready),  32'(vecs[v].e_ready));
         chk($sformatf("v%0d_s1busy", v), 32'(src1_busy),
             32'(FWD ? (vecs[v].e_s1b & ~vecs[v].e_hit1) : vecs[v].e_s1b));
         chk($sformatf("v%0d_fwd1v", v), 32'(fwd1_valid), 32'(FWD & vecs[v].e_hit1));
         chk($sformatf("v%0d_fwd1d", v), 32'(fwd1_data),
             32'((FWD && vecs[v].e_hit1) ? vecs[v].e_fd1 : 16'h0));
         chk($sformatf("v%0d_s2busy", v), 32'(src2_busy), 32'(vecs[v].e_s2b));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_we", v),    32'(WriteReg), 32'(vecs[v].e_we));
         chk($sformatf("v%0d_dst", v),   32'(DstReg),   32'(vecs[v].e_dst));
         chk($sformatf("v%0d_data", v),  32'(DstData),  32'(vecs[v].e_dd));
         chk($sformatf("v%0d_count", v), 32'(count),    32'(vecs[v].e_cnt));
         chk($sformatf("v%0d_err", v),   32'(err),      32'(vecs[v].e_err));
      end

      // Back-to-back results for R1..R5 commit in order, one per cycle.
      for (int r = 1; r <= 5; r++) step(1, 4'(r), 0, 0, 16'h0);
      for (int r = 1; r <= 5; r++) begin
         @(negedge clk);
         drive(0, 0, 1, 4'(r), 16'hA000 + 16'(r), 0, 0);
         #1;
         chk($sformatf("stream_ready%0d", r), 32'(wb_ready), 32'd1);
         @(posedge clk);
         #1;
         chk($sformatf("stream_count%0d", r), 32'(count), 32'd1);
         chk($sformatf("stream_we%0d", r), 32'(WriteReg), 32'(r > 1));
         if (r > 1) begin
            chk($sformatf("stream_dst%0d", r),  32'(DstReg),  32'(r - 1));
            chk($sformatf("stream_data%0d", r), 32'(DstData), 32'h0000A000 + 32'(r - 1));
         end
      end
      step(0, 0, 0, 0, 16'h0);
      chk("stream_last_we",   32'(WriteReg), 32'd1);
      chk("stream_last_dst",  32'(DstReg),   32'd5);
      chk("stream_last_data", 32'(DstData),  32'h0000A005);
      chk("stream_count0",    32'(count),    32'd0);
      step(0, 0, 0, 0, 16'h0);
      chk("stream_idle_we",   32'(WriteReg), 32'd0);

      // Forwarding of a queued result on source port 2.
      step(1, 4'd9, 0, 0, 16'h0);
      @(negedge clk);
      drive(0, 0, 1, 4'd9, 16'h1234, 0, 4'd9);
      #1;
      chk("fwd_pre_s2busy", 32'(src2_busy), 32'd1);
      @(posedge clk);
      @(negedge clk);
      drive(0, 0, 0, 0, 16'h0, 0, 4'd9);
      #1;
      chk("fwd_count",   32'(count),      32'd1);
      chk("fwd_s2busy",  32'(src2_busy),  32'(!FWD));
      chk("fwd_valid",   32'(fwd2_valid), 32'(FWD));
      chk("fwd_data",    32'(fwd2_data),  FWD ? 32'h1234 : 32'h0);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("fwd_out_valid", 32'(fwd2_valid), 32'(FWD));
      step(0, 0, 0, 0, 16'h0);
      step(0, 0, 0, 0, 16'h0);
      @(negedge clk);
      drive(0, 0, 0, 0, 16'h0, 0, 4'd9);
      #1;
      chk("fwd_done_s2busy", 32'(src2_busy),  32'd0);
      chk("fwd_done_valid",  32'(fwd2_valid), 32'd0);

      // Asynchronous reset while a result is in the output stage and another queued.
      step(1, 4'd2, 0, 0, 16'h0);
      step(1, 4'd4, 0, 0, 16'h0);
      step(0, 0, 1, 4'd2, 16'h2222);
      step(0, 0, 1, 4'd4, 16'h4444);
      chk("pre_rst_we",    32'(WriteReg), 32'd1);
      chk("pre_rst_count", 32'(count),    32'd1);
      chk("pre_rst_err",   32'(err),      32'd1);
      @(negedge clk);
      drive(0, 0, 0, 0, 16'h0, 4'd4, 4'd2);
      rst = 1'b1;
      #1;
      chk("mid_rst_count", 32'(count),     32'd0);
      chk("mid_rst_we",    32'(WriteReg),  32'd0);
      chk("mid_rst_dst",   32'(DstReg),    32'd0);
      chk("mid_rst_data",  32'(DstData),   32'd0);
      chk("mid_rst_err",   32'(err),       32'd0);
      chk("mid_rst_s1b",   32'(src1_busy), 32'd0);
      chk("mid_rst_s2b",   32'(src2_busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step(0, 0, 0, 0, 16'h0);
         chk($sformatf("post_rst_we%0d", c), 32'(WriteReg), 32'd0);
         chk($sformatf("post_rst_count%0d", c), 32'(count), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
